// File: rtl/kl10_scd_pkg.sv
//------------------------------------------------------------------------------
// Module : kl10_scd_pkg
// Brief  : Operand-select, function and SC-op encodings for the SCD datapath.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package kl10_scd_pkg;

    localparam int SCD_SCW_DEFAULT   = 10;
    localparam int SCD_SHMAX_DEFAULT = 36;

    localparam logic [1:0] SCADA_FE    = 2'd0;
    localparam logic [1:0] SCADA_BYTEP = 2'd1;
    localparam logic [1:0] SCADA_EXP   = 2'd2;
    localparam logic [1:0] SCADA_MAGIC = 2'd3;

    localparam logic [1:0] SCADB_SC    = 2'd0;
    localparam logic [1:0] SCADB_BYTES = 2'd1;
    localparam logic [1:0] SCADB_ARLO  = 2'd2;
    localparam logic [1:0] SCADB_MAGIC = 2'd3;

    localparam logic [2:0] SCAD_A      = 3'd0;
    localparam logic [2:0] SCAD_AMB    = 3'd1;
    localparam logic [2:0] SCAD_APB    = 3'd2;
    localparam logic [2:0] SCAD_AM1    = 3'd3;
    localparam logic [2:0] SCAD_AP1    = 3'd4;
    localparam logic [2:0] SCAD_B      = 3'd5;
    localparam logic [2:0] SCAD_OR     = 3'd6;
    localparam logic [2:0] SCAD_AND    = 3'd7;

    localparam logic [1:0] SC_HOLD     = 2'd0;
    localparam logic [1:0] SC_SCAD     = 2'd1;
    localparam logic [1:0] SC_FE       = 2'd2;
    localparam logic [1:0] SC_STEP     = 2'd3;

endpackage

`default_nettype wire

// File: rtl/scd_scad.sv
//------------------------------------------------------------------------------
// Module : scd_scad
// Brief  : SCAD operand muxes and 10-bit ALU; purely combinational.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module scd_scad
    import kl10_scd_pkg::*;
#(
    parameter int SCW = SCD_SCW_DEFAULT
) (
    input  logic [0:SCW-1] i_fe,
    input  logic [0:SCW-1] i_sc,
    input  logic [0:35]    i_ar,
    input  logic [0:8]     i_magic,
    input  logic [1:0]     i_sel_a,
    input  logic [1:0]     i_sel_b,
    input  logic [2:0]     i_fn,
    output logic [0:SCW-1] o_scad,
    output logic           o_neg,
    output logic           o_zero
);

    logic [0:SCW-1] w_a;
    logic [0:SCW-1] w_b;
    logic [0:SCW-1] w_magic_sx;
    logic [0:7]     w_exp;
    logic           w_unused_ar;

    assign w_magic_sx  = {{(SCW-9){i_magic[0]}}, i_magic};
    // Exponent field is stored ones-complemented for negative numbers.
    assign w_exp       = i_ar[1:8] ^ {8{i_ar[0]}};
    assign w_unused_ar = ^i_ar[12:27];

    always_comb begin
        w_a = i_fe;
        case (i_sel_a)
            SCADA_FE:    w_a = i_fe;
            SCADA_BYTEP: w_a = {{(SCW-6){1'b0}}, i_ar[0:5]};
            SCADA_EXP:   w_a = {{(SCW-8){1'b0}}, w_exp};
            SCADA_MAGIC: w_a = w_magic_sx;
            default:     w_a = i_fe;
        endcase
    end

    always_comb begin
        w_b = i_sc;
        case (i_sel_b)
            SCADB_SC:    w_b = i_sc;
            SCADB_BYTES: w_b = {{(SCW-6){1'b0}}, i_ar[6:11]};
            SCADB_ARLO:  w_b = {{(SCW-8){1'b0}}, i_ar[28:35]};
            SCADB_MAGIC: w_b = w_magic_sx;
            default:     w_b = i_sc;
        endcase
    end

    always_comb begin
        o_scad = w_a;
        case (i_fn)
            SCAD_A:   o_scad = w_a;
            SCAD_AMB: o_scad = w_a - w_b;
            SCAD_APB: o_scad = w_a + w_b;
            SCAD_AM1: o_scad = w_a - SCW'(1);
            SCAD_AP1: o_scad = w_a + SCW'(1);
            SCAD_B:   o_scad = w_b;
            SCAD_OR:  o_scad = w_a | w_b;
            SCAD_AND: o_scad = w_a & w_b;
            default:  o_scad = w_a;
        endcase
    end

    assign o_neg  = o_scad[0];
    assign o_zero = (o_scad == '0);

endmodule

`default_nettype wire

// File: rtl/scd.sv
//------------------------------------------------------------------------------
// Module : scd
// Brief  : SC/FE registers, SC step counter, loop-done pulse, SHM shift count.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module scd
    import kl10_scd_pkg::*;
#(
    parameter int SCW   = SCD_SCW_DEFAULT,
    parameter int SHMAX = SCD_SHMAX_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [0:35]    EDP_AR,
    input  logic [0:8]     CRAM_MAGIC,
    input  logic [1:0]     CRAM_SCADA,
    input  logic [1:0]     CRAM_SCADB,
    input  logic [2:0]     CRAM_SCAD,
    input  logic [1:0]     CRAM_SC,
    input  logic           CRAM_FE,
    output logic [0:SCW-1] SCD_SC,
    output logic [0:SCW-1] SCD_FE,
    output logic [0:SCW-1] SCD_SCAD,
    output logic           SCD_SCADneg,
    output logic           SCD_SCADzero,
    output logic [5:0]     SCD_SHcount,
    output logic           SCD_loopDone
);

    logic [0:SCW-1] r_sc;
    logic [0:SCW-1] r_fe;
    logic           r_loop_done;
    logic [0:SCW-1] w_scad;
    logic [0:SCW-1] w_sc_next;
    logic           w_sc_zero;

    scd_scad #(
        .SCW (SCW)
    ) u_scad (
        .i_fe    (r_fe),
        .i_sc    (r_sc),
        .i_ar    (EDP_AR),
        .i_magic (CRAM_MAGIC),
        .i_sel_a (CRAM_SCADA),
        .i_sel_b (CRAM_SCADB),
        .i_fn    (CRAM_SCAD),
        .o_scad  (w_scad),
        .o_neg   (SCD_SCADneg),
        .o_zero  (SCD_SCADzero)
    );

    assign w_sc_zero = (r_sc == '0);

    always_comb begin
        w_sc_next = r_sc;
        case (CRAM_SC)
            SC_HOLD: w_sc_next = r_sc;
            SC_SCAD: w_sc_next = w_scad;
            SC_FE:   w_sc_next = r_fe;
            // Step saturates at zero so a stray extra step cannot wrap.
            SC_STEP: w_sc_next = w_sc_zero ? r_sc : (r_sc - SCW'(1));
            default: w_sc_next = r_sc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sc        <= '0;
            r_fe        <= '0;
            r_loop_done <= 1'b0;
        end else begin
            r_sc        <= w_sc_next;
            if (CRAM_FE) begin
                r_fe    <= w_scad;
            end
            r_loop_done <= (CRAM_SC == SC_STEP) && (r_sc == SCW'(1));
        end
    end

    // Negative counts shift nothing; large counts clamp to a full shift-out.
    always_comb begin
        SCD_SHcount = r_sc[SCW-6:SCW-1];
        if (r_sc[0]) begin
            SCD_SHcount = 6'd0;
        end else if (r_sc >= SCW'(SHMAX)) begin
            SCD_SHcount = 6'(SHMAX);
        end
    end

    assign SCD_SC       = r_sc;
    assign SCD_FE       = r_fe;
    assign SCD_SCAD     = w_scad;
    assign SCD_loopDone = r_loop_done;

endmodule

`default_nettype wire

// File: tb/tb_scd.sv
//------------------------------------------------------------------------------
// Module : tb_scd
// Brief  : Directed and random checks of scd against an integer reference model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_scd;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:35] ar;
    logic [0:8]  magic;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [2:0]  fn;
    logic [1:0]  sc_op;
    logic        fe_ld;
    logic [0:9]  sc_o;
    logic [0:9]  fe_o;
    logic [0:9]  scad_o;
    logic        neg_o;
    logic        zero_o;
    logic [5:0]  shcount_o;
    logic        loop_done_o;

    int n_assert = 0;
    int n_fail   = 0;
    int m_sc     = 0;
    int m_fe     = 0;
    int m_ld     = 0;

    always #5 clk = ~clk;

    scd dut (
        .clk          (clk),
        .reset        (reset),
        .EDP_AR       (ar),
        .CRAM_MAGIC   (magic),
        .CRAM_SCADA   (sel_a),
        .CRAM_SCADB   (sel_b),
        .CRAM_SCAD    (fn),
        .CRAM_SC      (sc_op),
        .CRAM_FE      (fe_ld),
        .SCD_SC       (sc_o),
        .SCD_FE       (fe_o),
        .SCD_SCAD     (scad_o),
        .SCD_SCADneg  (neg_o),
        .SCD_SCADzero (zero_o),
        .SCD_SHcount  (shcount_o),
        .SCD_loopDone (loop_done_o)
    );

    // Reference SCAD from current inputs and model state, plain integer math.
    function automatic int ref_scad();
        int a, b, mg, ex, r;
        mg = int'(magic);
        if (mg >= 256) mg = mg - 512;
        mg = mg & 1023;
        ex = int'(ar >> 27) & 255;
        if (int'(ar >> 35) == 1) ex = ex ^ 255;
        case (sel_a)
            2'd0:    a = m_fe;
            2'd1:    a = int'(ar >> 30) & 63;
            2'd2:    a = ex;
            default: a = mg;
        endcase
        case (sel_b)
            2'd0:    b = m_sc;
            2'd1:    b = int'(ar >> 24) & 63;
            2'd2:    b = int'(ar) & 255;
            default: b = mg;
        endcase
        case (fn)
            3'd0:    r = a;
            3'd1:    r = a - b;
            3'd2:    r = a + b;
            3'd3:    r = a - 1;
            3'd4:    r = a + 1;
            3'd5:    r = b;
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r & 1023;
    endfunction

    function automatic int ref_shcount(input int sc);
        if (sc >= 512) return 0;
        if (sc >= 36) return 36;
        return sc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic [1:0] a, input logic [1:0] b,
                         input logic [2:0] f, input logic [1:0] op, input logic fe,
                         input logic [35:0] ar_v, input logic [8:0] mg_v);
        int r;
        @(negedge clk);
        reset = rst; sel_a = a; sel_b = b; fn = f; sc_op = op; fe_ld = fe;
        ar = ar_v; magic = mg_v;
        #1;
        r = ref_scad();
        chk("scad", 32'(scad_o), 32'(r));
        chk("scad_neg", 32'(neg_o), 32'(r >= 512));
        chk("scad_zero", 32'(zero_o), 32'(r == 0));
    endtask

    task automatic tick();
        int r, n_sc, n_fe, n_ld;
        r = ref_scad();
        if (reset) begin
            n_sc = 0; n_fe = 0; n_ld = 0;
        end else begin
            case (sc_op)
                2'd0:    n_sc = m_sc;
                2'd1:    n_sc = r;
                2'd2:    n_sc = m_fe;
                default: n_sc = (m_sc != 0) ? m_sc - 1 : 0;
            endcase
            n_fe = fe_ld ? r : m_fe;
            n_ld = (sc_op == 2'd3 && m_sc == 1) ? 1 : 0;
        end
        @(posedge clk);
        m_sc = n_sc; m_fe = n_fe; m_ld = n_ld;
        #1;
        chk("sc", 32'(sc_o), 32'(m_sc));
        chk("fe", 32'(fe_o), 32'(m_fe));
        chk("loop_done", 32'(loop_done_o), 32'(m_ld));
        chk("shcount", 32'(shcount_o), 32'(ref_shcount(m_sc)));
    endtask

    initial begin
        reset = 1'b1; sel_a = '0; sel_b = '0; fn = '0; sc_op = '0; fe_ld = 1'b0;
        ar = '0; magic = '0;
        tick();

        // Preload SC=5, FE=7, then reset while SC load is requested.
        apply(1'b0, 2'd0, 2'd3, 3'd5, 2'd1, 1'b0, 36'd0, 9'd5); tick();
        apply(1'b0, 2'd0, 2'd3, 3'd5, 2'd0, 1'b1, 36'd0, 9'd7); tick();
        apply(1'b1, 2'd0, 2'd3, 3'd5, 2'd1, 1'b1, 36'd0, 9'd9); tick();
        chk("reset_sc", 32'(sc_o), 32'd0);
        chk("reset_fe", 32'(fe_o), 32'd0);

        // Loop count 3 down to 0, then one extra step.
        apply(1'b0, 2'd0, 2'd3, 3'd5, 2'd1, 1'b0, 36'd0, 9'o003); tick();
        chk("loop_load", 32'(sc_o), 32'd3);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 2'd0, 2'd0, 3'd0, 2'd3, 1'b0, 36'd0, 9'd0); tick();
        end
        chk("loop_zero", 32'(sc_o), 32'd0);
        chk("loop_pulse", 32'(loop_done_o), 32'd1);
        apply(1'b0, 2'd0, 2'd0, 3'd0, 2'd3, 1'b0, 36'd0, 9'd0); tick();
        chk("loop_extra_pulse", 32'(loop_done_o), 32'd0);
        chk("loop_extra_sc", 32'(sc_o), 32'd0);

        // Byte pointer P=36, S=7: P-S.
        apply(1'b0, 2'd1, 2'd1, 3'd1, 2'd0, 1'b1, {6'o44, 6'o07, 24'd0}, 9'd0);
        chk("bp_scad", 32'(scad_o), 32'd29);
        chk("bp_neg", 32'(neg_o), 32'd0);
        tick();
        chk("bp_fe", 32'(fe_o), 32'd29);

        // FE=0 minus one wraps to all ones.
        apply(1'b0, 2'd0, 2'd3, 3'd5, 2'd0, 1'b1, 36'd0, 9'd0); tick();
        apply(1'b0, 2'd0, 2'd0, 3'd3, 2'd1, 1'b0, 36'd0, 9'd0);
        chk("wrap_scad", 32'(scad_o), 32'h3FF);
        chk("wrap_neg", 32'(neg_o), 32'd1);
        tick();
        chk("wrap_shcount", 32'(shcount_o), 32'd0);

        // Shift-count saturation boundary.
        apply(1'b0, 2'd0, 2'd3, 3'd5, 2'd1, 1'b0, 36'd0, 9'd35); tick();
        chk("sat35", 32'(shcount_o), 32'd35);
        apply(1'b0, 2'd0, 2'd3, 3'd5, 2'd1, 1'b0, 36'd0, 9'd36); tick();
        chk("sat36", 32'(shcount_o), 32'd36);
        apply(1'b0, 2'd0, 2'd3, 3'd5, 2'd1, 1'b0, 36'd0, 9'd100); tick();
        chk("sat100", 32'(shcount_o), 32'd36);

        // SC takes old FE while FE loads SCAD in the same cycle.
        apply(1'b0, 2'd0, 2'd3, 3'd5, 2'd0, 1'b1, 36'd0, 9'd12); tick();
        apply(1'b0, 2'd0, 2'd3, 3'd5, 2'd2, 1'b1, 36'd0, 9'd40); tick();
        chk("simul_sc", 32'(sc_o), 32'd12);
        chk("simul_fe", 32'(fe_o), 32'd40);

        // Random traffic; occasional reset, step-heavy to exercise loopDone.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] op_r;
            op_r = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd3;
            apply(($urandom_range(0, 31) == 0), 2'($urandom), 2'($urandom), 3'($urandom),
                  op_r, 1'($urandom), {4'($urandom), 32'($urandom)},
                  (($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 12)) : 9'($urandom)));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
